dmem_arbiter: RTL

// Shares the single-port data memory between two requesters: m0 (CPU load/store) and
// m1 (debug/DMA loader). Arbitration is round-robin with a bounded burst: an owner

---
 rtl/dmem_arbiter.sv | 86 ++++++++
 1 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin, burst-bounded sharing of one single-port dmem between m0 and m1
// Ports:
//   clk, reset                        clock, asynchronous active-high reset
//   mX_req/we/addr/wdata              requester X beat (held until mX_gnt)
//   mX_gnt                            combinational accept
//   mX_rvalid/rdata/err               registered response, one cycle after accept
//   mem_addr/mem_wdata/mem_wen/mem_q  dmem port (mem_q is a combinational read)
module dmem_arbiter #(
    parameter int DWIDTH    = 32,
    parameter int AWIDTH    = 32,
    parameter int MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [AWIDTH-1:0] m0_addr,
    input  logic [DWIDTH-1:0] m0_wdata,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [DWIDTH-1:0] m0_rdata,
    output logic              m0_err,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [AWIDTH-1:0] m1_addr,
    input  logic [DWIDTH-1:0] m1_wdata,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [DWIDTH-1:0] m1_rdata,
    output logic              m1_err,
    output logic [AWIDTH-1:0] mem_addr,
    output logic [DWIDTH-1:0] mem_wdata,
    output logic              mem_wen,
    input  logic [DWIDTH-1:0] mem_q
);
    localparam int CW = $clog2(MAX_BURST + 1);
    typedef enum logic [1:0] {IDLE, OWN0, OWN1} owner_t;
    owner_t        owner;
    logic          last;
    logic [CW-1:0] cnt;
    logic          full, sel1, beat, same, mis0, mis1, sel_we, sel_mis;
    assign full = (cnt == CW'(MAX_BURST));
    assign mis0 = |m0_addr[1:0];
    assign mis1 = |m1_addr[1:0];
    // m1 wins when alone, when it owns and has budget left, when m0's budget is
    // spent, or on an idle tie where m0 went last.
    assign sel1 = m1_req & (!m0_req | (owner == OWN1 ? !full : owner == OWN0 ? full : !last));
    assign m1_gnt  = sel1;
    assign m0_gnt  = m0_req & !sel1;
    assign beat    = m0_gnt | m1_gnt;
    assign same    = sel1 ? (owner == OWN1) : (owner == OWN0);
    assign sel_we  = sel1 ? m1_we : m0_we;
    assign sel_mis = sel1 ? mis1 : mis0;
    assign mem_addr  = m1_gnt ? m1_addr : m0_gnt ? m0_addr : '0;
    assign mem_wdata = m1_gnt ? m1_wdata : m0_gnt ? m0_wdata : '0;
    assign mem_wen   = beat & sel_we & !sel_mis;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            owner     <= IDLE;
            last      <= 1'b1;
            cnt       <= '0;
            m0_rvalid <= 1'b0;
            m0_err    <= 1'b0;
            m0_rdata  <= '0;
            m1_rvalid <= 1'b0;
            m1_err    <= 1'b0;
            m1_rdata  <= '0;
        end else begin
            if (beat) begin
                owner <= sel1 ? OWN1 : OWN0;
                last  <= sel1;
                // saturate so a lone requester keeps streaming
                cnt   <= same ? (full ? cnt : cnt + 1'b1) : CW'(1);
            end else begin
                owner <= IDLE;
                cnt   <= '0;
            end
            m0_rvalid <= m0_gnt;
            m0_err    <= m0_gnt & mis0;
            m0_rdata  <= (m0_gnt & !m0_we & !mis0) ? mem_q : '0;
            m1_rvalid <= m1_gnt;
            m1_err    <= m1_gnt & mis1;
            m1_rdata  <= (m1_gnt & !m1_we & !mis1) ? mem_q : '0;
        end
    end
endmodule
